ball_collision_array: RTL and testbench
=======================================

Name: ball_collision_array

Overview:
- Parametrised successor to the two-ball collision handler. Resolves elastic, equal-mass collisions among NUM_BALLS balls once per frame.
- Detects overlap geometrically from centre distance, not from draw-request coincidence. Keeps a per-pair arming flag with a hysteresis re-arm distance.
- Sits between the ball movement blocks and the hit/velocity mux. Scans all pairs sequentially after each startOfFrame, with one shared iterative divider.

Parameters:
- NUM_BALLS, 4, number of balls (2..16)
- COORD_W, 11, unsigned top-left coordinate width
- VEL_W, 11, signed velocity width
- BALL_DIAM, 32, ball diameter in pixels; overlap when d2 <= BALL_DIAM^2
- REARM_DIST, 36, pair re-arms when d2 >= REARM_DIST^2 (must be > BALL_DIAM)
- DIV_W, 32, internal arithmetic/divider width

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse; starts a scan
- posX  in  NUM_BALLS x COORD_W  top-left X per ball
- posY  in  NUM_BALLS x COORD_W  top-left Y per ball
- velXIn  in  NUM_BALLS x VEL_W signed  current X velocity
- velYIn  in  NUM_BALLS x VEL_W signed  current Y velocity
- velXOut  out  NUM_BALLS x VEL_W signed  resolved X velocity
- velYOut  out  NUM_BALLS x VEL_W signed  resolved Y velocity
- velValid  out  1  one-cycle pulse; velXOut/velYOut updated this cycle
- busy  out  1  scan in progress
- collisionOccurred  out  1  one-cycle pulse per resolved pair
- collisionPairA, collisionPairB  out  $clog2(NUM_BALLS) each  indices of the pair; valid with the pulse

Behaviour:
- Clock and reset: one clock clk; reset resetN, asynchronous, active-low.
- Reset values:
  - All outputs 0, FSM in IDLE.
  - All pair flags armed (1).
  - Working registers 0.
- IDLE:
  - On startOfFrame, snapshot posX/posY/velXIn/velYIn into working registers, set pair index to (0,1), go to CHECK.
  - busy is 1 from the next cycle until DONE.
- CHECK (1 cycle per pair (i,j)):
  - dx = posX[j]-posX[i], dy = posY[j]-posY[i], sign-extended to DIV_W.
  - d2 = dx*dx + dy*dy.
  - dot = (vx[j]-vx[i])*dx + (vy[j]-vy[i])*dy.
  - If d2 >= REARM_DIST^2: set flag(i,j) to 1.
  - Collide when flag(i,j) && d2 != 0 && d2 <= BALL_DIAM^2 && dot < 0. Then clear the flag, latch px = dot*dx and py = dot*dy, go to DIVX.
  - Otherwise advance to the next pair.
- Order of pairs: (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
- DIVX / DIVY:
  - Start the divider with px/d2, then py/d2. Signed quotient, truncated toward zero. Each divide takes DIV_W+1 cycles, start to done.
- APPLY (1 cycle):
  - vx[i] += qx, vy[i] += qy, vx[j] -= qx, vy[j] -= qy.
  - Each result saturates to the VEL_W signed range.
  - Pulse collisionOccurred with collisionPairA=i, collisionPairB=j.
  - Advance to the next pair.
- Working velocities update in place, so later pairs in the same scan see earlier results (chain collisions propagate within one frame).
- After the last pair, go to DONE (1 cycle): copy working velocities to velXOut/velYOut, pulse velValid, go to IDLE.
- Outputs hold their values between scans; there is no combinational passthrough.
- Timing:
  - Non-colliding pair costs 1 cycle.
  - Colliding pair costs 1 + 2*(DIV_W+1) + 1 cycles.
  - Worst case for all pairs colliding must complete within one frame at the 25 MHz, 640x480 timing.
- startOfFrame while busy is ignored; there is no queueing.
- resetN asserted mid-scan aborts immediately and applies the reset values above.
- d2 == 0 (coincident balls) is never divided; the pair is skipped with no pulse.
- Position/velocity inputs are sampled only at startOfFrame; input changes during a scan are ignored.

Decomposition:
- Package ball_phys_pkg holds:
  - typedefs coord_t, vel_t (signed), wide_t (DIV_W signed), ball_idx_t
  - FSM enum {IDLE, CHECK, DIVX, DIVY, APPLY, DONE}
  - function pair_flag_index(i,j) mapping a pair to a flat flag bit; NUM_BALLS*(NUM_BALLS-1)/2 flags
  - saturating vel_sat function
- Sub-module seq_signed_divider:
  - Restoring, DIV_W iterations, handshake start/done.
  - Asynchronous active-low reset on resetN.
  - Divide-by-zero returns 0; never triggered by the top.

Test Plan:
- Head-on swap: N=2, ball0 (100,100) v(4,0), ball1 (130,100) v(-4,0), pulse startOfFrame.
  - Expect one collisionOccurred with pair (0,1).
  - Then velValid with v0=(-4,0), v1=(4,0) (d2=900, dot=-240, q=(-8,0)).
- Separating: same positions, v0=(-4,0), v1=(4,0).
  - Expect no collision pulse; velValid with unchanged velocities.
- Hysteresis:
  - After the head-on case, repeat with approaching velocities at d=30: no collision.
  - Then a frame at d=40 (d2=1600 >= 1296) re-arms; the next frame at d=30 collides again.
- Chain, N=3: balls at x=100,130,160 (y=100), v0=(4,0), others 0.
  - Expect pulses for (0,1) then (1,2).
  - Final v=(0,0),(0,0),(4,0).
- Coincident: two balls at identical positions, approaching.
  - Expect no pulse, no divider start, velocities unchanged, scan completes.
- Robustness:
  - startOfFrame while busy is ignored (exactly one velValid per accepted start).
  - resetN low during DIVX: all outputs 0, busy 0, flags re-armed; the next frame behaves as from reset.

Source files
------------

// File: rtl/ball_phys_pkg.sv
// Shared types, FSM encoding and arithmetic helpers for the ball collision array.
package ball_phys_pkg;
  localparam int DEF_COORD_W = 11;
  localparam int DEF_VEL_W   = 11;
  localparam int DEF_DIV_W   = 32;
  localparam int MAX_BALLS   = 16;

  typedef logic        [DEF_COORD_W-1:0]       coord_t;
  typedef logic signed [DEF_VEL_W-1:0]         vel_t;
  typedef logic signed [DEF_DIV_W-1:0]         wide_t;
  typedef logic        [$clog2(MAX_BALLS)-1:0] ball_idx_t;

  typedef enum logic [2:0] {IDLE, CHECK, DIVX, DIVY, APPLY, DONE} state_t;

  // Flat index of pair (i,j), i<j, in row-major upper-triangle order.
  function automatic int pair_flag_index(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic logic signed [63:0] vel_sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/seq_signed_divider.sv
// Restoring signed divider: one quotient bit per cycle, quotient truncated toward zero.
module seq_signed_divider #(
  parameter int DIV_W = 32
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    start,
  input  logic signed [DIV_W-1:0] dividend,
  input  logic signed [DIV_W-1:0] divisor,
  output logic signed [DIV_W-1:0] quotient,
  output logic                    done
);
  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] r_q;
  logic [DIV_W-1:0] r_d;
  logic [DIV_W:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_neg;
  logic             r_zero;

  logic [DIV_W-1:0] w_abs_num;
  logic [DIV_W-1:0] w_abs_den;
  logic [DIV_W:0]   w_shift;
  logic [DIV_W:0]   w_trial;
  logic             w_bit;
  logic [DIV_W-1:0] w_q_next;

  assign w_abs_num = dividend[DIV_W-1] ? DIV_W'(-dividend) : DIV_W'(dividend);
  assign w_abs_den = divisor[DIV_W-1]  ? DIV_W'(-divisor)  : DIV_W'(divisor);
  assign w_shift   = {r_rem[DIV_W-1:0], r_q[DIV_W-1]};
  assign w_trial   = w_shift - {1'b0, r_d};
  assign w_bit     = ~w_trial[DIV_W];
  assign w_q_next  = {r_q[DIV_W-2:0], w_bit};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_q      <= '0;
      r_d      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_neg    <= 1'b0;
      r_zero   <= 1'b0;
      quotient <= '0;
      done     <= 1'b0;
    end else if (start) begin
      r_q    <= w_abs_num;
      r_d    <= w_abs_den;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b1;
      r_neg  <= dividend[DIV_W-1] ^ divisor[DIV_W-1];
      r_zero <= (divisor == '0);
      done   <= 1'b0;
    end else if (r_run) begin
      r_rem <= w_bit ? w_trial : w_shift;
      r_q   <= w_q_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(DIV_W - 1)) begin
        r_run    <= 1'b0;
        done     <= 1'b1;
        // Zero divisor yields zero rather than the all-ones restoring result.
        quotient <= r_zero ? '0 : (r_neg ? -$signed(w_q_next) : $signed(w_q_next));
      end
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/ball_collision_array.sv
// Per-frame sequential pairwise elastic collision resolver for NUM_BALLS equal-mass balls.
module ball_collision_array
  import ball_phys_pkg::*;
#(
  parameter int NUM_BALLS  = 4,
  parameter int COORD_W    = 11,
  parameter int VEL_W      = 11,
  parameter int BALL_DIAM  = 32,
  parameter int REARM_DIST = 36,
  parameter int DIV_W      = 32,
  localparam int IDX_W     = $clog2(NUM_BALLS)
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic                                startOfFrame,
  input  logic [NUM_BALLS-1:0][COORD_W-1:0]   posX,
  input  logic [NUM_BALLS-1:0][COORD_W-1:0]   posY,
  input  logic [NUM_BALLS-1:0][VEL_W-1:0]     velXIn,
  input  logic [NUM_BALLS-1:0][VEL_W-1:0]     velYIn,
  output logic [NUM_BALLS-1:0][VEL_W-1:0]     velXOut,
  output logic [NUM_BALLS-1:0][VEL_W-1:0]     velYOut,
  output logic                                velValid,
  output logic                                busy,
  output logic                                collisionOccurred,
  output logic [IDX_W-1:0]                    collisionPairA,
  output logic [IDX_W-1:0]                    collisionPairB
);
  localparam int NPAIRS = NUM_BALLS * (NUM_BALLS - 1) / 2;
  localparam int PIDX_W = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam logic signed [DIV_W-1:0] DIAM2  = DIV_W'(BALL_DIAM * BALL_DIAM);
  localparam logic signed [DIV_W-1:0] REARM2 = DIV_W'(REARM_DIST * REARM_DIST);

  state_t r_state, w_next;
  logic [NUM_BALLS-1:0][COORD_W-1:0] r_px, r_py;
  logic signed [VEL_W-1:0] r_vx [NUM_BALLS];
  logic signed [VEL_W-1:0] r_vy [NUM_BALLS];
  logic [IDX_W-1:0]  r_i, r_j;
  logic [NPAIRS-1:0] r_flag;
  logic signed [DIV_W-1:0] r_d2, r_pny, r_qx, r_qy;

  logic signed [DIV_W-1:0] w_xi, w_xj, w_yi, w_yj, w_vxi, w_vxj, w_vyi, w_vyj;
  logic signed [DIV_W-1:0] w_dx, w_dy, w_d2, w_dot, w_pnx, w_pny;
  logic signed [DIV_W-1:0] w_nvxi, w_nvxj, w_nvyi, w_nvyj;
  logic signed [DIV_W-1:0] w_div_num, w_div_den, w_div_q;
  logic [PIDX_W-1:0] w_fidx;
  logic [IDX_W-1:0]  w_ni, w_nj;
  logic w_collide, w_rearm, w_last_j, w_last, w_div_start, w_div_done;

  assign w_xi  = DIV_W'(r_px[r_i]);
  assign w_xj  = DIV_W'(r_px[r_j]);
  assign w_yi  = DIV_W'(r_py[r_i]);
  assign w_yj  = DIV_W'(r_py[r_j]);
  assign w_vxi = DIV_W'(r_vx[r_i]);
  assign w_vxj = DIV_W'(r_vx[r_j]);
  assign w_vyi = DIV_W'(r_vy[r_i]);
  assign w_vyj = DIV_W'(r_vy[r_j]);

  assign w_dx  = w_xj - w_xi;
  assign w_dy  = w_yj - w_yi;
  assign w_d2  = w_dx * w_dx + w_dy * w_dy;
  assign w_dot = (w_vxj - w_vxi) * w_dx + (w_vyj - w_vyi) * w_dy;
  assign w_pnx = w_dot * w_dx;
  assign w_pny = w_dot * w_dy;

  assign w_fidx    = PIDX_W'(pair_flag_index(int'(r_i), int'(r_j), NUM_BALLS));
  assign w_rearm   = (w_d2 >= REARM2);
  assign w_collide = r_flag[w_fidx] && (w_d2 != '0) && (w_d2 <= DIAM2) && (w_dot < 0);
  assign w_last_j  = (r_j == IDX_W'(NUM_BALLS - 1));
  assign w_last    = w_last_j && (r_i == IDX_W'(NUM_BALLS - 2));
  assign w_ni      = w_last_j ? r_i + IDX_W'(1) : r_i;
  assign w_nj      = w_last_j ? r_i + IDX_W'(2) : r_j + IDX_W'(1);

  assign w_nvxi = w_vxi + r_qx;
  assign w_nvyi = w_vyi + r_qy;
  assign w_nvxj = w_vxj - r_qx;
  assign w_nvyj = w_vyj - r_qy;

  assign busy = (r_state != IDLE);

  seq_signed_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .resetN   (resetN),
    .start    (w_div_start),
    .dividend (w_div_num),
    .divisor  (w_div_den),
    .quotient (w_div_q),
    .done     (w_div_done)
  );

  always_comb begin
    w_next      = r_state;
    w_div_start = 1'b0;
    w_div_num   = w_pnx;
    w_div_den   = w_d2;
    case (r_state)
      IDLE:  if (startOfFrame) w_next = CHECK;
      CHECK: begin
        if (w_collide) begin
          w_next      = DIVX;
          w_div_start = 1'b1;
        end else if (w_last) begin
          w_next = DONE;
        end
      end
      DIVX: begin
        // Y numerator is launched the same cycle the X quotient lands.
        w_div_num = r_pny;
        w_div_den = r_d2;
        if (w_div_done) begin
          w_next      = DIVY;
          w_div_start = 1'b1;
        end
      end
      DIVY:    if (w_div_done) w_next = APPLY;
      APPLY:   w_next = w_last ? DONE : CHECK;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state           <= IDLE;
      r_px              <= '0;
      r_py              <= '0;
      r_i               <= '0;
      r_j               <= '0;
      r_flag            <= '1;
      r_d2              <= '0;
      r_pny             <= '0;
      r_qx              <= '0;
      r_qy              <= '0;
      velXOut           <= '0;
      velYOut           <= '0;
      velValid          <= 1'b0;
      collisionOccurred <= 1'b0;
      collisionPairA    <= '0;
      collisionPairB    <= '0;
      for (int k = 0; k < NUM_BALLS; k++) begin
        r_vx[k] <= '0;
        r_vy[k] <= '0;
      end
    end else begin
      r_state           <= w_next;
      velValid          <= 1'b0;
      collisionOccurred <= 1'b0;
      case (r_state)
        IDLE: begin
          if (startOfFrame) begin
            r_px <= posX;
            r_py <= posY;
            r_i  <= '0;
            r_j  <= IDX_W'(1);
            for (int k = 0; k < NUM_BALLS; k++) begin
              r_vx[k] <= velXIn[k];
              r_vy[k] <= velYIn[k];
            end
          end
        end
        CHECK: begin
          if (w_rearm) r_flag[w_fidx] <= 1'b1;
          if (w_collide) begin
            r_flag[w_fidx] <= 1'b0;
            r_d2           <= w_d2;
            r_pny          <= w_pny;
          end else begin
            r_i <= w_ni;
            r_j <= w_nj;
          end
        end
        DIVX: if (w_div_done) r_qx <= w_div_q;
        DIVY: if (w_div_done) r_qy <= w_div_q;
        APPLY: begin
          r_vx[r_i]         <= VEL_W'(vel_sat(64'(w_nvxi), VEL_W));
          r_vy[r_i]         <= VEL_W'(vel_sat(64'(w_nvyi), VEL_W));
          r_vx[r_j]         <= VEL_W'(vel_sat(64'(w_nvxj), VEL_W));
          r_vy[r_j]         <= VEL_W'(vel_sat(64'(w_nvyj), VEL_W));
          collisionOccurred <= 1'b1;
          collisionPairA    <= r_i;
          collisionPairB    <= r_j;
          r_i               <= w_ni;
          r_j               <= w_nj;
        end
        DONE: begin
          velValid <= 1'b1;
          for (int k = 0; k < NUM_BALLS; k++) begin
            velXOut[k] <= r_vx[k];
            velYOut[k] <= r_vy[k];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ball_collision_array.sv
// Bench for ball_collision_array: directed frame table, corner sequences, randomized frames vs a pair-loop model.
module tb_ball_collision_array;
  localparam int NB    = 3;
  localparam int CW    = 11;
  localparam int VW    = 11;
  localparam int DIAM  = 32;
  localparam int REARM = 36;
  localparam int DW    = 32;
  localparam int IW    = $clog2(NB);
  localparam int BASE_CYC = NB * (NB - 1) / 2 + 1;
  localparam int COLL_CYC = 2 * (DW + 1) + 1;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic [NB-1:0][CW-1:0] posX = '0, posY = '0;
  logic [NB-1:0][VW-1:0] velXIn = '0, velYIn = '0;
  logic [NB-1:0][VW-1:0] velXOut, velYOut;
  logic velValid, busy, collisionOccurred;
  logic [IW-1:0] collisionPairA, collisionPairB;

  ball_collision_array #(
    .NUM_BALLS(NB), .COORD_W(CW), .VEL_W(VW), .BALL_DIAM(DIAM), .REARM_DIST(REARM), .DIV_W(DW)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .posX(posX), .posY(posY), .velXIn(velXIn), .velYIn(velYIn),
    .velXOut(velXOut), .velYOut(velYOut), .velValid(velValid), .busy(busy),
    .collisionOccurred(collisionOccurred),
    .collisionPairA(collisionPairA), .collisionPairB(collisionPairB)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int coll_q[$];

  always @(negedge clk)
    if (collisionOccurred) coll_q.push_back(int'(collisionPairA) * 16 + int'(collisionPairB));

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Frame inputs, DUT results and reference-model state.
  int ipx[NB], ipy[NB], ivx[NB], ivy[NB];
  int ovx[NB], ovy[NB];
  int mvx[NB], mvy[NB];
  int m_pairs[$];
  bit mflag[NB][NB];

  function automatic int sat(input longint v);
    if (v > 1023) return 1023;
    if (v < -1024) return -1024;
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < NB; j++) mflag[i][j] = 1'b1;
  endtask

  // Elastic equal-mass exchange along the centre line, pairs in lexicographic order.
  task automatic model_frame();
    longint dx, dy, d2, dot, qx, qy;
    for (int k = 0; k < NB; k++) begin
      mvx[k] = ivx[k];
      mvy[k] = ivy[k];
    end
    m_pairs.delete();
    for (int i = 0; i < NB - 1; i++) begin
      for (int j = i + 1; j < NB; j++) begin
        dx  = longint'(ipx[j] - ipx[i]);
        dy  = longint'(ipy[j] - ipy[i]);
        d2  = dx * dx + dy * dy;
        dot = longint'(mvx[j] - mvx[i]) * dx + longint'(mvy[j] - mvy[i]) * dy;
        if (d2 >= REARM * REARM) mflag[i][j] = 1'b1;
        if (mflag[i][j] && d2 != 0 && d2 <= DIAM * DIAM && dot < 0) begin
          mflag[i][j] = 1'b0;
          qx = (dot * dx) / d2;
          qy = (dot * dy) / d2;
          mvx[i] = sat(mvx[i] + qx);
          mvy[i] = sat(mvy[i] + qy);
          mvx[j] = sat(mvx[j] - qx);
          mvy[j] = sat(mvy[j] - qy);
          m_pairs.push_back(i * 16 + j);
        end
      end
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NB; k++) begin
      posX[k]   = CW'(ipx[k]);
      posY[k]   = CW'(ipy[k]);
      velXIn[k] = VW'(ivx[k]);
      velYIn[k] = VW'(ivy[k]);
    end
  endtask

  task automatic run_frame(output int cyc);
    drive_inputs();
    coll_q.delete();
    model_frame();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    cyc = 0;
    while (velValid !== 1'b1 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    for (int k = 0; k < NB; k++) begin
      ovx[k] = int'($signed(velXOut[k]));
      ovy[k] = int'($signed(velYOut[k]));
    end
    @(negedge clk);
  endtask

  typedef logic [NB-1:0][15:0] tri_t;
  typedef struct {
    tri_t px, py, vx, vy, evx, evy;
    int   ncoll, pair0, pair1;
  } vec_t;

  function automatic tri_t t3(input int a, input int b, input int c);
    tri_t t;
    t[0] = 16'(a);
    t[1] = 16'(b);
    t[2] = 16'(c);
    return t;
  endfunction

  vec_t vecs[12];

  initial begin
    int cyc, cnt, p;

    // Flag state carries across rows, so order matters.
    vecs[0]  = '{t3(100,130,600), t3(100,100,400), t3(4,-4,0),  t3(0,0,0),  t3(-4,4,0), t3(0,0,0),  1, 1, -1};
    vecs[1]  = '{t3(100,130,600), t3(100,100,400), t3(-4,4,0),  t3(0,0,0),  t3(-4,4,0), t3(0,0,0),  0, -1, -1};
    vecs[2]  = '{t3(100,130,600), t3(100,100,400), t3(4,-4,0),  t3(0,0,0),  t3(4,-4,0), t3(0,0,0),  0, -1, -1};
    vecs[3]  = '{t3(100,140,600), t3(100,100,400), t3(4,-4,0),  t3(0,0,0),  t3(4,-4,0), t3(0,0,0),  0, -1, -1};
    vecs[4]  = '{t3(100,130,600), t3(100,100,400), t3(4,-4,0),  t3(0,0,0),  t3(-4,4,0), t3(0,0,0),  1, 1, -1};
    vecs[5]  = '{t3(100,200,300), t3(100,100,100), t3(1,2,3),   t3(-1,0,1), t3(1,2,3),  t3(-1,0,1), 0, -1, -1};
    vecs[6]  = '{t3(100,130,160), t3(100,100,100), t3(4,0,0),   t3(0,0,0),  t3(0,0,4),  t3(0,0,0),  2, 1, 18};
    vecs[7]  = '{t3(100,200,300), t3(100,100,100), t3(1,2,3),   t3(-1,0,1), t3(1,2,3),  t3(-1,0,1), 0, -1, -1};
    vecs[8]  = '{t3(200,200,600), t3(200,200,400), t3(4,-4,0),  t3(1,0,0),  t3(4,-4,0), t3(1,0,0),  0, -1, -1};
    vecs[9]  = '{t3(100,120,600), t3(100,120,400), t3(3,0,0),   t3(3,0,0),  t3(0,3,0),  t3(0,3,0),  1, 1, -1};
    vecs[10] = '{t3(100,200,300), t3(100,100,100), t3(1,2,3),   t3(-1,0,1), t3(1,2,3),  t3(-1,0,1), 0, -1, -1};
    vecs[11] = '{t3(100,121,600), t3(100,110,400), t3(5,0,0),   t3(0,0,0),  t3(1,4,0),  t3(-1,1,0), 1, 1, -1};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst velXOut", int'(|velXOut), 0);
    check("rst velYOut", int'(|velYOut), 0);
    check("rst busy", int'(busy), 0);
    check("rst velValid", int'(velValid), 0);
    check("rst collision", int'(collisionOccurred), 0);
    @(negedge clk);
    resetN = 1'b1;

    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < NB; k++) begin
        ipx[k] = int'(vecs[n].px[k]);
        ipy[k] = int'(vecs[n].py[k]);
        ivx[k] = int'($signed(vecs[n].vx[k]));
        ivy[k] = int'($signed(vecs[n].vy[k]));
      end
      run_frame(cyc);
      for (int k = 0; k < NB; k++) begin
        check($sformatf("vec%0d vx%0d", n, k), ovx[k], int'($signed(vecs[n].evx[k])));
        check($sformatf("vec%0d vy%0d", n, k), ovy[k], int'($signed(vecs[n].evy[k])));
      end
      check($sformatf("vec%0d ncoll", n), coll_q.size(), vecs[n].ncoll);
      if (vecs[n].ncoll > 0) check($sformatf("vec%0d pair0", n), (coll_q.size() > 0) ? coll_q[0] : -1, vecs[n].pair0);
      if (vecs[n].ncoll > 1) check($sformatf("vec%0d pair1", n), (coll_q.size() > 1) ? coll_q[1] : -1, vecs[n].pair1);
      check($sformatf("vec%0d cycles", n), cyc, BASE_CYC + COLL_CYC * vecs[n].ncoll);
    end

    // A second start while busy must not produce a second result.
    ipx = '{100, 200, 300}; ipy = '{100, 100, 100};
    ivx = '{5, -6, 7};      ivy = '{-3, 2, 1};
    drive_inputs();
    model_frame();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    check("busy after start", int'(busy), 1);
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (velValid) cnt++;
    end
    check("busy-ignore velValid count", cnt, 1);
    check("busy-ignore vx0", int'($signed(velXOut[0])), mvx[0]);
    check("busy-ignore vy2", int'($signed(velYOut[2])), mvy[2]);

    // Reset while the divider is working on the X component.
    ipx = '{100, 130, 600}; ipy = '{100, 100, 400};
    ivx = '{4, -4, 0};      ivy = '{0, 0, 0};
    drive_inputs();
    coll_q.delete();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    resetN = 1'b0;
    #1;
    check("midrst velXOut", int'(|velXOut), 0);
    check("midrst velYOut", int'(|velYOut), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst velValid", int'(velValid), 0);
    check("midrst pairA", int'(collisionPairA), 0);
    check("midrst pulses", coll_q.size(), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    run_frame(cyc);
    check("postrst vx0", ovx[0], -4);
    check("postrst vx1", ovx[1], 4);
    check("postrst ncoll", coll_q.size(), 1);
    check("postrst cycles", cyc, BASE_CYC + COLL_CYC);

    // Randomized clustered frames against the model.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NB; k++) begin
        ipx[k] = int'($urandom_range(140, 100));
        ipy[k] = int'($urandom_range(140, 100));
        ivx[k] = int'($urandom_range(60, 0)) - 30;
        ivy[k] = int'($urandom_range(60, 0)) - 30;
      end
      run_frame(cyc);
      for (int k = 0; k < NB; k++) begin
        check($sformatf("rnd%0d vx%0d", n, k), ovx[k], mvx[k]);
        check($sformatf("rnd%0d vy%0d", n, k), ovy[k], mvy[k]);
      end
      check($sformatf("rnd%0d ncoll", n), coll_q.size(), m_pairs.size());
      for (int q = 0; q < m_pairs.size(); q++) begin
        p = (q < coll_q.size()) ? coll_q[q] : -1;
        check($sformatf("rnd%0d pair%0d", n, q), p, m_pairs[q]);
      end
      check($sformatf("rnd%0d cycles", n), cyc, BASE_CYC + COLL_CYC * m_pairs.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
